// File: rtl/fm_cmn_pkg.sv
// Shared fm_cmn helpers: depth derivation and FIFO threshold legality tests.
package fm_cmn_pkg;

    function automatic int fm_cmn_depth(input int range);
        return 1 << range;
    endfunction

    function automatic bit fm_cmn_afull_ok(input int afull, input int range);
        return (afull >= 1) && (afull <= fm_cmn_depth(range));
    endfunction

    function automatic bit fm_cmn_aempty_ok(input int aempty, input int range);
        return (aempty >= 0) && (aempty <= fm_cmn_depth(range) - 1);
    endfunction

endpackage

// File: rtl/fm_cmn_bfifo_ex_if.sv
// Port bundle of the block-RAM FIFO: write/read/flush requests and status outputs.
interface fm_cmn_bfifo_ex_if #(
    parameter int P_WIDTH = 32,
    parameter int P_RANGE = 8
);
    logic               i_wstrobe;
    logic [P_WIDTH-1:0] i_dt;
    logic               i_renable;
    logic               i_flush;
    logic [P_WIDTH-1:0] o_dt;
    logic               o_empty;
    logic               o_full;
    logic               o_afull;
    logic               o_aempty;
    logic [P_RANGE:0]   o_dnum;
    logic               o_ovf;
    logic               o_udf;

    modport master (
        output i_wstrobe, i_dt, i_renable, i_flush,
        input  o_dt, o_empty, o_full, o_afull, o_aempty, o_dnum, o_ovf, o_udf
    );

    modport slave (
        input  i_wstrobe, i_dt, i_renable, i_flush,
        output o_dt, o_empty, o_full, o_afull, o_aempty, o_dnum, o_ovf, o_udf
    );
endinterface

// File: rtl/fm_cmn_bram_02.sv
// Simple dual-port RAM, P_WIDTH x 2**P_RANGE, with a registered 1-cycle read port.
module fm_cmn_bram_02 #(
    parameter int P_WIDTH = 32,
    parameter int P_RANGE = 8
) (
    input  logic               clk_core,
    input  logic               we,
    input  logic [P_RANGE-1:0] wa,
    input  logic [P_WIDTH-1:0] di,
    input  logic               re,
    input  logic [P_RANGE-1:0] ra,
    output logic [P_WIDTH-1:0] dout
);
    logic [P_WIDTH-1:0] mem [0:(1<<P_RANGE)-1];

    // dout holds its value whenever re is low; the FIFO relies on that.
    always_ff @(posedge clk_core) begin
        if (we) begin
            mem[wa] <= di;
        end
        if (re) begin
            dout <= mem[ra];
        end
    end
endmodule

// File: rtl/fm_cmn_bfifo_ex.sv
// First-word-fall-through FIFO over one block RAM, with programmable thresholds,
// synchronous flush and sticky overflow/underflow flags.
module fm_cmn_bfifo_ex
    import fm_cmn_pkg::*;
#(
    parameter int P_WIDTH  = 32,
    parameter int P_RANGE  = 8,
    parameter int P_AFULL  = fm_cmn_depth(P_RANGE) - 4,
    parameter int P_AEMPTY = 4
) (
    input  logic             clk_core,
    input  logic             rst,
    fm_cmn_bfifo_ex_if.slave bus
);
    localparam int P_DEPTH = fm_cmn_depth(P_RANGE);
    localparam int CW      = P_RANGE + 1;

    localparam logic [CW-1:0]      DEPTH_V  = CW'(P_DEPTH);
    localparam logic [CW-1:0]      AFULL_V  = CW'(P_AFULL);
    localparam logic [CW-1:0]      AEMPTY_V = CW'(P_AEMPTY);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [P_RANGE-1:0] PTR_ONE  = P_RANGE'(1);

    generate
        if (!fm_cmn_afull_ok(P_AFULL, P_RANGE)) begin : g_bad_afull
            $error("fm_cmn_bfifo_ex: P_AFULL outside 1..P_DEPTH");
        end
        if (!fm_cmn_aempty_ok(P_AEMPTY, P_RANGE)) begin : g_bad_aempty
            $error("fm_cmn_bfifo_ex: P_AEMPTY outside 0..P_DEPTH-1");
        end
    endgenerate

    logic [P_RANGE-1:0] wptr_reg;
    logic [P_RANGE-1:0] rptr_reg;
    logic [CW-1:0]      dnum_reg;
    logic [CW-1:0]      dnum_next;
    logic               head_valid_reg;
    logic [P_WIDTH-1:0] head_dt_reg;
    logic               dout_valid_reg;
    logic               ovf_reg;
    logic               udf_reg;
    logic [P_WIDTH-1:0] ram_dout;

    logic          w_full;
    logic          w_we;
    logic          w_re;
    logic [CW-1:0] w_staged;
    logic          w_ram_avail;
    logic          w_move;
    logic          w_issue;

    // Two-stage head: RAM output register (dout_valid) feeds the head register,
    // so a pop can be refilled from dout on the same edge for 1 word/cycle.
    always_comb begin
        w_full      = (dnum_reg == DEPTH_V);
        w_we        = bus.i_wstrobe & ~w_full & ~bus.i_flush;
        w_re        = bus.i_renable & head_valid_reg & ~bus.i_flush;
        w_staged    = CW'(head_valid_reg) + CW'(dout_valid_reg);
        w_ram_avail = (dnum_reg > w_staged);
        w_move      = dout_valid_reg & (~head_valid_reg | w_re);
        w_issue     = w_ram_avail & (~dout_valid_reg | w_move) & ~bus.i_flush;

        dnum_next = dnum_reg;
        case ({w_we, w_re})
            2'b10:   dnum_next = dnum_reg + CNT_ONE;
            2'b01:   dnum_next = dnum_reg - CNT_ONE;
            default: dnum_next = dnum_reg;
        endcase
    end

    fm_cmn_bram_02 #(
        .P_WIDTH (P_WIDTH),
        .P_RANGE (P_RANGE)
    ) u_ram (
        .clk_core (clk_core),
        .we       (w_we),
        .wa       (wptr_reg),
        .di       (bus.i_dt),
        .re       (w_issue),
        .ra       (rptr_reg),
        .dout     (ram_dout)
    );

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            dnum_reg       <= '0;
            head_valid_reg <= 1'b0;
            head_dt_reg    <= '0;
            dout_valid_reg <= 1'b0;
            ovf_reg        <= 1'b0;
            udf_reg        <= 1'b0;
        end else if (bus.i_flush) begin
            // RAM contents and the last head word are left as they are.
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            dnum_reg       <= '0;
            head_valid_reg <= 1'b0;
            dout_valid_reg <= 1'b0;
            ovf_reg        <= 1'b0;
            udf_reg        <= 1'b0;
        end else begin
            if (w_we) begin
                wptr_reg <= wptr_reg + PTR_ONE;
            end
            if (w_issue) begin
                rptr_reg <= rptr_reg + PTR_ONE;
            end
            dnum_reg <= dnum_next;

            if (w_move) begin
                head_dt_reg    <= ram_dout;
                head_valid_reg <= 1'b1;
            end else if (w_re) begin
                head_valid_reg <= 1'b0;
            end

            if (w_issue) begin
                dout_valid_reg <= 1'b1;
            end else if (w_move) begin
                dout_valid_reg <= 1'b0;
            end

            ovf_reg <= ovf_reg | (bus.i_wstrobe & w_full);
            udf_reg <= udf_reg | (bus.i_renable & ~head_valid_reg);
        end
    end

    assign bus.o_dt     = head_dt_reg;
    assign bus.o_empty  = ~head_valid_reg;
    assign bus.o_full   = w_full;
    assign bus.o_afull  = (dnum_reg >= AFULL_V);
    assign bus.o_aempty = (dnum_reg <= AEMPTY_V);
    assign bus.o_dnum   = dnum_reg;
    assign bus.o_ovf    = ovf_reg;
    assign bus.o_udf    = udf_reg;
endmodule

// File: tb/tb_fm_cmn_bfifo_ex.sv
// Scoreboard bench for fm_cmn_bfifo_ex: 16-entry FIFO, thresholds 12/4.
module tb_fm_cmn_bfifo_ex;
    localparam int W     = 32;
    localparam int R     = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic clk_core = 1'b0;
    logic rst      = 1'b1;

    int n_checks = 0;
    int n_errs   = 0;

    logic [W-1:0] sb_q[$];
    bit           m_ovf = 1'b0;
    bit           m_udf = 1'b0;

    fm_cmn_bfifo_ex_if #(.P_WIDTH(W), .P_RANGE(R)) bus ();

    fm_cmn_bfifo_ex #(
        .P_WIDTH  (W),
        .P_RANGE  (R),
        .P_AFULL  (AF),
        .P_AEMPTY (AE)
    ) u_dut (
        .clk_core (clk_core),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk_core = ~clk_core;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_empty"},  64'(bus.o_empty),  64'd1);
        check_val({tag, "_full"},   64'(bus.o_full),   64'd0);
        check_val({tag, "_afull"},  64'(bus.o_afull),  64'd0);
        check_val({tag, "_aempty"}, 64'(bus.o_aempty), 64'd1);
        check_val({tag, "_dnum"},   64'(bus.o_dnum),   64'd0);
        check_val({tag, "_ovf"},    64'(bus.o_ovf),    64'd0);
        check_val({tag, "_udf"},    64'(bus.o_udf),    64'd0);
        check_val({tag, "_dt"},     64'(bus.o_dt),     64'd0);
    endtask

    // One clock of stimulus; called 1 time unit after a rising edge.
    task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic f);
        bit           we_acc;
        bit           re_acc;
        logic [W-1:0] exp_dt;
        int           cnt;
        bus.i_wstrobe = w;
        bus.i_dt      = d;
        bus.i_renable = r;
        bus.i_flush   = f;
        cnt    = sb_q.size();
        we_acc = w && (cnt != DEPTH) && !f;
        re_acc = r && !bus.o_empty && !f;
        if (w && cnt == DEPTH) m_ovf = 1'b1;
        if (r && bus.o_empty)  m_udf = 1'b1;
        if (re_acc) begin
            if (sb_q.size() == 0) begin
                check_val("sb_underrun", 64'(bus.o_dt), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_dt = sb_q.pop_front();
                $display("pop  dt=0x%08h exp=0x%08h", bus.o_dt, exp_dt);
                check_val("pop_dt", 64'(bus.o_dt), 64'(exp_dt));
            end
        end
        if (we_acc) begin
            sb_q.push_back(d);
            $display("push dt=0x%08h", d);
        end
        if (f) begin
            sb_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            $display("flush");
        end
        @(posedge clk_core);
        #1;
        bus.i_wstrobe = 1'b0;
        bus.i_renable = 1'b0;
        bus.i_flush   = 1'b0;
        cnt = sb_q.size();
        check_val("dnum",   64'(bus.o_dnum),   64'(cnt));
        check_val("full",   64'(bus.o_full),   64'(cnt == DEPTH));
        check_val("afull",  64'(bus.o_afull),  64'(cnt >= AF));
        check_val("aempty", 64'(bus.o_aempty), 64'(cnt <= AE));
        check_val("ovf",    64'(bus.o_ovf),    64'(m_ovf));
        check_val("udf",    64'(bus.o_udf),    64'(m_udf));
        if (cnt == 0) check_val("empty_at_zero", 64'(bus.o_empty), 64'd1);
    endtask

    task automatic drain_to(input int level);
        for (int k = 0; k < 80 && sb_q.size() > level; k++) begin
            step(1'b0, '0, !bus.o_empty, 1'b0);
        end
        check_val("drain_level", 64'(sb_q.size()), 64'(level));
    endtask

    initial begin
        bus.i_wstrobe = 1'b0;
        bus.i_dt      = '0;
        bus.i_renable = 1'b0;
        bus.i_flush   = 1'b0;
        repeat (3) @(posedge clk_core);
        #1;
        check_reset_vals("rst_hold");
        @(negedge clk_core);
        rst = 1'b0;
        @(posedge clk_core);
        #1;
        check_reset_vals("rst_rel");

        // First fill latency and basic order
        step(1'b1, 32'h11, 1'b0, 1'b0);
        check_val("lat_n0_empty", 64'(bus.o_empty), 64'd1);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        check_val("lat_n1_empty", 64'(bus.o_empty), 64'd1);
        step(1'b1, 32'h33, 1'b0, 1'b0);
        check_val("lat_n2_empty", 64'(bus.o_empty), 64'd0);
        check_val("lat_n2_dt",    64'(bus.o_dt),    64'h11);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0);
        check_val("three_pop_empty", 64'(bus.o_empty), 64'd1);

        // Fill to full, overflow, then full with simultaneous write+read
        for (int k = 0; k < DEPTH; k++) step(1'b1, 32'h100 + 32'(k), 1'b0, 1'b0);
        check_val("fill_full", 64'(bus.o_full), 64'd1);
        step(1'b1, 32'hDEAD, 1'b0, 1'b0);
        check_val("ovf_set", 64'(bus.o_ovf), 64'd1);
        check_val("full_head_ready", 64'(bus.o_empty), 64'd0);
        step(1'b1, 32'hBEEF, 1'b1, 1'b0);
        check_val("full_wr_dnum", 64'(bus.o_dnum), 64'd15);

        // Flush at dnum=7 with a write pending and ovf set
        drain_to(7);
        check_val("pre_flush_ovf", 64'(bus.o_ovf), 64'd1);
        step(1'b1, 32'h5555, 1'b0, 1'b1);
        check_val("flush_dnum",  64'(bus.o_dnum),  64'd0);
        check_val("flush_empty", 64'(bus.o_empty), 64'd1);
        check_val("flush_ovf",   64'(bus.o_ovf),   64'd0);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, 1'b0);
        check_val("flush_stays_empty", 64'(bus.o_empty), 64'd1);

        // Empty with simultaneous write+read
        step(1'b1, 32'hABC, 1'b1, 1'b0);
        check_val("empty_wr_dnum", 64'(bus.o_dnum), 64'd1);
        check_val("empty_wr_udf",  64'(bus.o_udf),  64'd1);
        drain_to(0);

        // Pointer wrap with count hovering around the almost-empty threshold
        for (int k = 0; k < 6; k++) step(1'b1, 32'h2000 + 32'(k), 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) step(1'b1, 32'h3000 + 32'(k), !bus.o_empty, 1'b0);
        drain_to(0);

        // Asynchronous reset mid-burst
        step(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 32'h4000 + 32'(k), 1'b0, 1'b0);
        bus.i_wstrobe = 1'b1;
        bus.i_dt      = 32'h4444;
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        bus.i_wstrobe = 1'b0;
        sb_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(negedge clk_core);
        rst = 1'b0;
        @(posedge clk_core);
        #1;
        check_reset_vals("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fm_cmn_bfifo_ex.md
# fm_cmn_bfifo_ex

Parametrised block-RAM FIFO with first-word-fall-through output, programmable almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow flags. It is the general-purpose buffering FIFO for the fm_cmn library, used between memory-interface and pipeline stages that need early back-pressure and error visibility. Storage is one synchronous-read dual-port RAM with a registered head-of-queue output stage.

## Interface
- P_WIDTH, 32: data width in bits.
- P_RANGE, 8: address width; P_DEPTH = 1 << P_RANGE is the total capacity in entries.
- P_AFULL, P_DEPTH-4: o_afull asserts when stored count >= P_AFULL; legal range 1..P_DEPTH.
- P_AEMPTY, 4: o_aempty asserts when stored count <= P_AEMPTY; legal range 0..P_DEPTH-1.

- clk_core  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_wstrobe  in  1  write request.
- i_dt  in  P_WIDTH  write data.
- i_renable  in  1  read request (pop the head).
- i_flush  in  1  synchronous clear.
- o_dt  out  P_WIDTH  head-of-queue data, valid while o_empty=0.
- o_empty  out  1  no valid head word.
- o_full  out  1  stored count == P_DEPTH.
- o_afull  out  1  almost full.
- o_aempty  out  1  almost empty.
- o_dnum  out  P_RANGE+1  stored count, 0..P_DEPTH.
- o_ovf  out  1  sticky: a write was attempted while o_full=1.
- o_udf  out  1  sticky: a read was attempted while o_empty=1.

## Operation
- Accepted write: w_we = i_wstrobe & !o_full & !i_flush. Accepted read: w_re = i_renable & !o_empty & !i_flush.
- Read and write pointers are P_RANGE bits wide and wrap modulo P_DEPTH with no special casing.
- o_dnum counts all stored words, including the word in the head register: +1 on a write only, -1 on a read only, unchanged when both or neither occur.
- Head stage: a RAM read is issued whenever the head register is empty, or is being popped this cycle, and the RAM holds unread words. Returned data loads the head register and o_empty falls.
- When the FIFO is full, a simultaneous write and read accepts the read and rejects the write. The write raises o_ovf.
- When the FIFO is empty, a simultaneous write and read accepts the write and ignores the read. The read raises o_udf.
- i_flush has priority over everything else. In the next cycle the pointers, o_dnum and head-valid are cleared, and o_ovf and o_udf are cleared. RAM contents are left unchanged.
- o_full, o_afull and o_aempty are decoded combinationally from the o_dnum register. o_empty comes from the head-valid register.

## Timing
- Reset values: o_empty=1, o_full=0, o_afull=0 (o_afull=1 only if P_AFULL==0, which is illegal), o_aempty=1, o_dnum=0, o_ovf=0, o_udf=0, o_dt=0.
- Write into an empty FIFO at edge N: o_dnum=1 after edge N; o_empty falls after edge N+2 (RAM write, then registered read). During that window o_dnum can be nonzero while o_empty=1. This is legal and documented.
- Back-to-back pops are sustained at one word per cycle once the head stage is primed.
- o_dt changes only on a pop or on the first fill. It is stable while i_renable=0.
- Reset asserted mid-operation clears all state asynchronously. Outputs take their reset values while rst=1.

## Structure
- Shared package fm_cmn_pkg: the P_DEPTH derivation and the threshold legality checks (elaboration-time assertions).
- Sub-module fm_cmn_bram_02: simple dual-port RAM, P_WIDTH x P_DEPTH. It has a write port (we, wa, di) and a registered read port (re, ra, do) with 1-cycle read latency.
- The top level holds the pointers, the count, the head register, the flags and the flush logic.

## Test plan
- After reset, write 0x11, 0x22, 0x33 on consecutive cycles. o_empty falls 2 cycles after the first write with o_dt=0x11. Three pops then return 0x11, 0x22, 0x33, after which o_empty=1 and o_dnum=0.
- Fill P_DEPTH words (P_RANGE=4, 16 words). o_full=1 at o_dnum=16, and o_afull=1 from o_dnum=12. A 17th write is dropped, o_ovf=1, and the data read back is unchanged.
- With the FIFO full, assert i_wstrobe and i_renable together. The read is accepted, the write is rejected, o_dnum=15 and o_ovf=1.
- With the FIFO empty, assert i_wstrobe and i_renable together. o_dnum=1, o_udf=1, and the written word later appears on o_dt.
- Run 40 push/pop pairs through a 16-entry FIFO to exercise pointer wrap. Data order is preserved, and o_aempty toggles exactly at o_dnum 4/5.
- Assert i_flush with o_dnum=7, i_wstrobe=1 and o_ovf=1. Next cycle: o_dnum=0, o_empty=1, o_ovf=0, and the write is discarded. Separately, assert rst mid-burst and check that every output returns to its reset value at once.
